cpu_bus1_master: RTL

CPU_BUS1_MASTER -- requirements
Module: cpu_bus1_master

---
 rtl/cpu_bus1_master_if.sv | 34 +++
 rtl/cpu_bus1_master.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cpu_bus1_master_if.sv
// Requester-side bundle for cpu_bus1_master: two request ports
// plus the shared grant/done/err/rdata return path.
interface cpu_bus1_master_if #(
  parameter int ADDR1_BUS_SIZE    = 15,
  parameter int CACHE_OFFSET_SIZE = 4
);
  localparam int BW = ADDR1_BUS_SIZE + CACHE_OFFSET_SIZE;

  logic [1:0]    req;
  logic [2:0]    cmd0;
  logic [2:0]    cmd1;
  logic [BW-1:0] addr0;
  logic [BW-1:0] addr1;
  logic [31:0]   wdata0;
  logic [31:0]   wdata1;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic [1:0]    err;
  logic [31:0]   rdata;

  modport master (
    input  req, cmd0, cmd1,
    input  addr0, addr1,
    input  wdata0, wdata1,
    output gnt, done, err, rdata
  );

  modport slave (
    output req, cmd0, cmd1,
    output addr0, addr1,
    output wdata0, wdata1,
    input  gnt, done, err, rdata
  );
endinterface

// File: rtl/cpu_bus1_master.sv
// cpu_bus1_master: round-robin arbiter for two requesters that
// sequences command, address and response on the A1/D1/C1 bus.
module cpu_bus1_master #(
  parameter int ADDR1_BUS_SIZE    = 15,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int DATA_BUS_SIZE     = 16,
  parameter int CTR1_BUS_SIZE     = 3,
  parameter int RESP_TIMEOUT      = 255
) (
  input  logic                      CLK,
  input  logic                      RESET,
  cpu_bus1_master_if.master         bus,
  inout  wire [ADDR1_BUS_SIZE-1:0]  A1,
  inout  wire [DATA_BUS_SIZE-1:0]   D1,
  inout  wire [CTR1_BUS_SIZE-1:0]   C1
);
  localparam int AW = ADDR1_BUS_SIZE;
  localparam int OW = CACHE_OFFSET_SIZE;
  localparam int DW = DATA_BUS_SIZE;
  localparam int CW = CTR1_BUS_SIZE;
  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  localparam logic [2:0] NOP      = 3'd0;
  localparam logic [2:0] READ8    = 3'd1;
  localparam logic [2:0] READ16   = 3'd2;
  localparam logic [2:0] READ32   = 3'd3;
  localparam logic [2:0] INVAL    = 3'd4;
  localparam logic [2:0] WRITE32  = 3'd7;
  localparam logic [2:0] RESPONSE = 3'd7;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_LO, WAIT_RESP, DATA2, DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             prio;
  logic             win;
  logic [2:0]       cmd_q;
  logic [AW+OW-1:0] addr_q;
  logic [31:0]      wdata_q;
  logic [TW-1:0]    cnt;
  logic [15:0]      rlo;
  logic [31:0]      rdata_q;
  logic             tout;

  logic             pick;
  logic [2:0]       pick_cmd;
  logic [AW+OW-1:0] pick_addr;
  logic [31:0]      pick_wdata;
  logic [15:0]      d_in;
  logic [31:0]      resp_data;
  logic             is_wr;
  logic             drv;
  logic             resp;
  logic             last;
  logic [1:0]       win_oh;
  logic [AW-1:0]    a_val;
  logic [15:0]      d_val;

  assign pick       = bus.req[prio] ? prio : ~prio;
  assign pick_cmd   = pick ? bus.cmd1 : bus.cmd0;
  assign pick_addr  = pick ? bus.addr1 : bus.addr0;
  assign pick_wdata = pick ? bus.wdata1 : bus.wdata0;

  assign d_in  = 16'(D1);
  assign is_wr = cmd_q[2] && (cmd_q != INVAL);
  assign drv   = (state == CMD) || (state == ADDR_LO);
  // cnt==0 is the turnaround cycle; C1 is still settling there
  assign resp  = (C1 == CW'(RESPONSE)) && (cnt != '0);
  assign last  = (cnt == TW'(RESP_TIMEOUT - 1));

  assign a_val = (state == CMD) ? addr_q[AW+OW-1:OW]
                                : AW'(addr_q[OW-1:0]);
  assign d_val = (state == ADDR_LO && cmd_q == WRITE32)
               ? wdata_q[31:16] : wdata_q[15:0];

  assign A1 = drv ? a_val : 'z;
  assign C1 = drv ? CW'(cmd_q) : 'z;
  assign D1 = (drv && is_wr) ? DW'(d_val) : 'z;

  assign win_oh    = win ? 2'b10 : 2'b01;
  assign bus.gnt   = (state != IDLE) ? win_oh : 2'b00;
  assign bus.done  = (state == DONE) ? win_oh : 2'b00;
  assign bus.err   = (state == DONE && tout) ? win_oh : 2'b00;
  assign bus.rdata = rdata_q;

  always_comb begin
    resp_data = '0;
    unique case (1'b1)
      cmd_q == READ8:  resp_data = {24'd0, d_in[7:0]};
      cmd_q == READ16: resp_data = {16'd0, d_in};
      default:         resp_data = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (|bus.req)
          state_nx = (pick_cmd == NOP) ? DONE : CMD;
      CMD:     state_nx = ADDR_LO;
      ADDR_LO: state_nx = WAIT_RESP;
      WAIT_RESP:
        if (resp)
          state_nx = (cmd_q == READ32) ? DATA2 : DONE;
        else if (last)
          state_nx = DONE;
      DATA2:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      prio    <= 1'b0;
      win     <= 1'b0;
      cmd_q   <= NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      rlo     <= '0;
      rdata_q <= '0;
      tout    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE:
          if (|bus.req) begin
            win     <= pick;
            cmd_q   <= pick_cmd;
            addr_q  <= pick_addr;
            wdata_q <= pick_wdata;
            tout    <= 1'b0;
            if (pick_cmd == NOP)
              rdata_q <= '0;
          end
        ADDR_LO: cnt <= '0;
        WAIT_RESP: begin
          cnt <= cnt + 1'b1;
          if (resp) begin
            rlo <= d_in;
            if (cmd_q != READ32)
              rdata_q <= resp_data;
          end else if (last) begin
            tout    <= 1'b1;
            rdata_q <= '0;
          end
        end
        DATA2: rdata_q <= {d_in, rlo};
        DONE:  prio <= ~win;
        default: ;
      endcase
    end
  end
endmodule
